dmem_responder: RTL and testbench

- Data-memory responder: the slave end of the core's load/store port (wr, rd, addr[8:0], wr_data, rd_data).
- Holds a 512-byte byte-addressable array organised as 128 x 32-bit words.
- Services byte, half and word accesses with sign or zero extension, inserts a programmable number of wait states, and flags misaligned or illegal requests.
- Sits between the datapath memory port and the top level; the core must stall while ready is low.

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core load/store port.
// 512-byte byte-addressable array, B/H/W accesses with sign/zero extension,
// programmable wait states, and error pulses for misaligned/illegal requests.
module dmem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ready,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  LAST  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic [2:0]          lat_f3;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_wr;
  logic [DATA_W-1:0]   rd_hold;
  logic [7:0]          mem [DEPTH];

  logic [ADDR_W-3:0]   word_idx;
  logic [DATA_W-1:0]   cur_word;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   wlane;
  logic [3:0]          be;
  logic                bad;
  logic                load_ok;

  // State register, wait counter, request latch and held load result
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rd_hold <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && (wr || rd)) begin
        lat_addr  <= addr;
        lat_f3    <= funct3;
        lat_wdata <= wr_data;
        lat_wr    <= wr;  // wr wins when both are high
      end
      if (state == S_WAIT) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 4'd1;
      end
      if (load_ok) begin
        rd_hold <= load_val;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (wr || rd) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == LAST) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Error decode, load extraction/extension and store byte-enable generation
  always_comb begin
    bad      = 1'b0;
    load_val = '0;
    be       = 4'b0000;
    wlane    = lat_wdata;
    word_idx = lat_addr[ADDR_W-1:2];
    cur_word = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
    shifted  = cur_word >> {lat_addr[1:0], 3'b000};

    case (lat_f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = lat_addr[0];
      3'b010:         bad = |lat_addr[1:0];
      default:        bad = 1'b1;
    endcase

    case (lat_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      3'b010:  load_val = cur_word;
      default: load_val = '0;
    endcase

    // Store data is replicated across lanes; byte enables pick the target bytes
    case (lat_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << lat_addr[1:0];
        wlane = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{lat_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = lat_wdata;
      end
    endcase

    load_ok = (state == S_RESP) && !lat_wr && !bad;
  end

  // Array write, committed at the end of RESP unless aborted by reset
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && lat_wr && !bad) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[{word_idx, 2'(i)}] <= wlane[8*i +: 8];
      end
    end
  end

  assign ready    = (state == S_IDLE);
  assign rd_valid = load_ok;
  assign err      = (state == S_RESP) && bad;
  assign rd_data  = load_ok ? load_val : rd_hold;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with 0 and 3 wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, wr0, rd0, rv0, rdy0, err0;
  logic [8:0]  addr0;
  logic [2:0]  f0;
  logic [31:0] wd0, rdd0;

  logic        reset3, wr3, rd3, rv3, rdy3, err3;
  logic [8:0]  addr3;
  logic [2:0]  f3;
  logic [31:0] wd3, rdd3;

  int checks   = 0;
  int failures = 0;
  logic [31:0] held0 = '0;
  logic [31:0] held3 = '0;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset0), .wr(wr0), .rd(rd0), .addr(addr0), .funct3(f0),
    .wr_data(wd0), .rd_data(rdd0), .rd_valid(rv0), .ready(rdy0), .err(err0)
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset3), .wr(wr3), .rd(rd3), .addr(addr3), .funct3(f3),
    .wr_data(wd3), .rd_data(rdd3), .rd_valid(rv3), .ready(rdy3), .err(err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on the zero-wait instance; response cycle then idle cycle checked
  task automatic acc0(input string tag, input logic w, input logic r, input logic [8:0] a,
                      input logic [2:0] f, input logic [31:0] d,
                      input logic ev, input logic ee, input logic [31:0] ed);
    @(negedge clk);
    wr0 = w; rd0 = r; addr0 = a; f0 = f; wd0 = d;
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b0;
    if (ev) held0 = ed;
    check_eq({tag, ".ready"}, 32'(rdy0), 32'd0);
    check_eq({tag, ".valid"}, 32'(rv0), 32'(ev));
    check_eq({tag, ".err"}, 32'(err0), 32'(ee));
    check_eq({tag, ".data"}, rdd0, held0);
    @(posedge clk); #1;
    check_eq({tag, ".ready_after"}, 32'(rdy0), 32'd1);
    check_eq({tag, ".valid_after"}, 32'(rv0), 32'd0);
    check_eq({tag, ".err_after"}, 32'(err0), 32'd0);
    check_eq({tag, ".data_hold"}, rdd0, held0);
  endtask

  // One access on the three-wait instance
  task automatic acc3(input string tag, input logic w, input logic r, input logic [8:0] a,
                      input logic [2:0] f, input logic [31:0] d,
                      input logic ev, input logic [31:0] ed);
    @(negedge clk);
    wr3 = w; rd3 = r; addr3 = a; f3 = f; wd3 = d;
    @(posedge clk); #1;
    wr3 = 1'b0; rd3 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check_eq({tag, ".busy"}, {31'd0, rdy3 | rv3}, 32'd0);
      @(posedge clk); #1;
    end
    if (ev) held3 = ed;
    check_eq({tag, ".ready"}, 32'(rdy3), 32'd0);
    check_eq({tag, ".valid"}, 32'(rv3), 32'(ev));
    check_eq({tag, ".data"}, rdd3, held3);
    @(posedge clk); #1;
    check_eq({tag, ".ready_after"}, 32'(rdy3), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset0 = 1'b1; wr0 = 1'b0; rd0 = 1'b0; addr0 = '0; f0 = '0; wd0 = '0;
    reset3 = 1'b1; wr3 = 1'b0; rd3 = 1'b0; addr3 = '0; f3 = '0; wd3 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset0 = 1'b0; reset3 = 1'b0;
    check_eq("rst0.ready", 32'(rdy0), 32'd1);
    check_eq("rst0.valid", 32'(rv0), 32'd0);
    check_eq("rst0.err", 32'(err0), 32'd0);
    check_eq("rst0.data", rdd0, 32'd0);
    check_eq("rst3.ready", 32'(rdy3), 32'd1);
    check_eq("rst3.data", rdd3, 32'd0);

    // Word store/load
    acc0("sw000", 1, 0, 9'h000, 3'b010, 32'h01020304, 0, 0, 0);
    acc0("sw010", 1, 0, 9'h010, 3'b010, 32'hDEADBEEF, 0, 0, 0);
    acc0("lw010", 0, 1, 9'h010, 3'b010, 32'h0, 1, 0, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads
    acc0("sw010b", 1, 0, 9'h010, 3'b010, 32'h11223344, 0, 0, 0);
    acc0("sb013", 1, 0, 9'h013, 3'b000, 32'h000000F0, 0, 0, 0);
    acc0("lb013", 0, 1, 9'h013, 3'b000, 32'h0, 1, 0, 32'hFFFFFFF0);
    acc0("lbu013", 0, 1, 9'h013, 3'b100, 32'h0, 1, 0, 32'h000000F0);
    acc0("lw010b", 0, 1, 9'h010, 3'b010, 32'h0, 1, 0, 32'hF0223344);

    // Half store and signed/unsigned half loads
    acc0("sw020", 1, 0, 9'h020, 3'b010, 32'h55667788, 0, 0, 0);
    acc0("sh022", 1, 0, 9'h022, 3'b001, 32'h00008001, 0, 0, 0);
    acc0("lh022", 0, 1, 9'h022, 3'b001, 32'h0, 1, 0, 32'hFFFF8001);
    acc0("lhu022", 0, 1, 9'h022, 3'b101, 32'h0, 1, 0, 32'h00008001);
    acc0("lw020", 0, 1, 9'h020, 3'b010, 32'h0, 1, 0, 32'h80017788);

    // Misaligned and illegal requests
    acc0("lw005", 0, 1, 9'h005, 3'b010, 32'h0, 0, 1, 0);
    acc0("sh003", 1, 0, 9'h003, 3'b001, 32'h0000BEEF, 0, 1, 0);
    acc0("f011", 0, 1, 9'h010, 3'b011, 32'h0, 0, 1, 0);
    acc0("sf110", 1, 0, 9'h010, 3'b110, 32'h0, 0, 1, 0);
    acc0("lhu021", 0, 1, 9'h021, 3'b101, 32'h0, 0, 1, 0);
    acc0("lw000", 0, 1, 9'h000, 3'b010, 32'h0, 1, 0, 32'h01020304);
    acc0("lw010c", 0, 1, 9'h010, 3'b010, 32'h0, 1, 0, 32'hF0223344);

    // wr and rd together: store only
    acc0("swrd040", 1, 1, 9'h040, 3'b010, 32'hA5A5A5A5, 0, 0, 0);
    acc0("lw040", 0, 1, 9'h040, 3'b010, 32'h0, 1, 0, 32'hA5A5A5A5);

    // Three wait states: timing and ignored request during WAIT
    acc3("w3sw044", 1, 0, 9'h044, 3'b010, 32'h12345678, 0, 0);
    @(negedge clk);
    rd3 = 1'b1; addr3 = 9'h044; f3 = 3'b010;
    @(posedge clk); #1;
    rd3 = 1'b0;
    check_eq("w3.c1.ready", 32'(rdy3), 32'd0);
    @(posedge clk); #1;
    check_eq("w3.c2.ready", 32'(rdy3), 32'd0);
    rd3 = 1'b1; addr3 = 9'h010;
    @(posedge clk); #1;
    rd3 = 1'b0; addr3 = 9'h044;
    check_eq("w3.c3.ready", 32'(rdy3), 32'd0);
    check_eq("w3.c3.valid", 32'(rv3), 32'd0);
    @(posedge clk); #1;
    held3 = 32'h12345678;
    check_eq("w3.c4.ready", 32'(rdy3), 32'd0);
    check_eq("w3.c4.valid", 32'(rv3), 32'd1);
    check_eq("w3.c4.data", rdd3, held3);
    @(posedge clk); #1;
    check_eq("w3.c5.ready", 32'(rdy3), 32'd1);
    check_eq("w3.c5.valid", 32'(rv3), 32'd0);
    @(posedge clk); #1;
    check_eq("w3.c6.ready", 32'(rdy3), 32'd1);
    check_eq("w3.c6.valid", 32'(rv3), 32'd0);

    // Reset during WAIT of a store aborts it
    @(negedge clk);
    wr3 = 1'b1; addr3 = 9'h044; f3 = 3'b010; wd3 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    wr3 = 1'b0;
    reset3 = 1'b1;
    @(posedge clk); #1;
    reset3 = 1'b0;
    held3 = '0;
    check_eq("w3rst.ready", 32'(rdy3), 32'd1);
    check_eq("w3rst.valid", 32'(rv3), 32'd0);
    check_eq("w3rst.data", rdd3, 32'd0);
    acc3("w3lw044", 0, 1, 9'h044, 3'b010, 32'h0, 1, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
